// File: rtl/skew_shift_buffer.sv
// skew_shift_buffer: multi-lane delay line with uniform or skewed per-lane delay
// and a drain/flush state machine.
// Optional build macro ZERO_INVALID_EN: when defined, words entering the chain
// with valid=0 are stored as zero so invalid outputs read as clean zero padding.
module skew_shift_buffer #(
  parameter int DATA_W = 16,
  parameter int LANES  = 8,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         shift_en,
  input  logic                         mode,
  input  logic [$clog2(DEPTH+1)-1:0]   cfg_delay,
  input  logic [LANES-1:0]             in_valid,
  input  logic [LANES*DATA_W-1:0]      in_data,
  output logic                         in_ready,
  output logic [LANES-1:0]             out_valid,
  output logic [LANES*DATA_W-1:0]      out_data,
  output logic                         busy,
  input  logic                         flush,
  output logic                         flush_done
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            act_mode;
  logic [CW-1:0]   act_delay;

  logic [DATA_W-1:0] stage_data [LANES][DEPTH];
  logic              stage_vld  [LANES][DEPTH];
  logic [DATA_W-1:0] out_word   [LANES];

  logic [DATA_W-1:0] in_word  [LANES];
  logic [LANES-1:0]  in_vld;
  logic [DATA_W-1:0] tap_data [LANES];
  logic              tap_vld  [LANES];
  logic [CW-1:0]     lane_d   [LANES];
  logic              adv;
  logic              entering;

  function automatic logic [CW-1:0] clamp_delay(input logic [CW-1:0] d);
    return (d > DEPTH_C) ? DEPTH_C : d;
  endfunction

  function automatic logic [CW-1:0] skew_delay(input int lane);
    return (lane > DEPTH) ? DEPTH_C : CW'(lane);
  endfunction

  assign in_ready = (state != DRAIN);
  assign adv      = (shift_en && in_ready) || (state == DRAIN);
  assign entering = adv && (|in_vld);

  // Unpack lane inputs; drain forces valid low, optional zero gating of invalid words
  always_comb begin
    in_vld = '0;
    for (int i = 0; i < LANES; i++) begin
      in_word[i] = in_data[i*DATA_W +: DATA_W];
      in_vld[i]  = in_valid[i] && (state != DRAIN);
`ifdef ZERO_INVALID_EN
      if (!in_vld[i]) in_word[i] = '0;
`else
      in_word[i] = in_word[i];
`endif
    end
  end

  // Per-lane delay from the frozen active configuration
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_d[i] = act_mode ? skew_delay(i) : act_delay;
    end
  end

  // Tap select: delay 0 bypasses the chain, otherwise read stage[d-1]
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      tap_data[i] = in_word[i];
      tap_vld[i]  = in_vld[i];
      for (int k = 0; k < DEPTH; k++) begin
        if (int'(lane_d[i]) == k + 1) begin
          tap_data[i] = stage_data[i][k];
          tap_vld[i]  = stage_vld[i][k];
        end
      end
    end
  end

  // Busy reflects in-flight chain contents only, not the output registers
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        busy = busy | stage_vld[i][k];
      end
    end
  end

  // Delay chain and output registers advance together, hold otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        for (int k = 0; k < DEPTH; k++) begin
          stage_data[i][k] <= '0;
          stage_vld[i][k]  <= 1'b0;
        end
        out_word[i]  <= '0;
        out_valid[i] <= 1'b0;
      end
    end else if (adv) begin
      for (int i = 0; i < LANES; i++) begin
        stage_data[i][0] <= in_word[i];
        stage_vld[i][0]  <= in_vld[i];
        for (int k = 1; k < DEPTH; k++) begin
          stage_data[i][k] <= stage_data[i][k-1];
          stage_vld[i][k]  <= stage_vld[i][k-1];
        end
        out_word[i]  <= tap_data[i];
        out_valid[i] <= tap_vld[i];
      end
    end
  end

  // Pack lane output words onto the flat bus
  always_comb begin
    out_data = '0;
    for (int i = 0; i < LANES; i++) begin
      out_data[i*DATA_W +: DATA_W] = out_word[i];
    end
  end

  // Active configuration tracks the ports only while idle and empty
  always_ff @(posedge clk) begin
    if (reset) begin
      act_mode  <= 1'b0;
      act_delay <= '0;
    end else if (!busy && state == IDLE) begin
      act_mode  <= mode;
      act_delay <= clamp_delay(cfg_delay);
    end
  end

  // FSM state and drain counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: flush enters DRAIN, which runs DEPTH+1 advances then pulses done
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else if (entering) begin
          state_n = ACTIVE;
        end
      end
      ACTIVE: begin
        if (flush) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end else if (!busy && !entering) begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (cnt == DEPTH_C) begin
          flush_done = 1'b1;
          state_n    = IDLE;
          cnt_n      = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_skew_shift_buffer.sv
// Testbench for skew_shift_buffer (LANES=4, DEPTH=4, DATA_W=16): directed
// scenarios followed by random traffic, checked against a history-based model.
module tb_skew_shift_buffer;
  localparam int DATA_W = 16;
  localparam int LANES  = 4;
  localparam int DEPTH  = 4;
  localparam int CW     = $clog2(DEPTH+1);

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    shift_en;
  logic                    mode;
  logic [CW-1:0]           cfg_delay;
  logic [LANES-1:0]        in_valid;
  logic [LANES*DATA_W-1:0] in_data;
  logic                    in_ready;
  logic [LANES-1:0]        out_valid;
  logic [LANES*DATA_W-1:0] out_data;
  logic                    busy;
  logic                    flush;
  logic                    flush_done;

  int total = 0;
  int bad   = 0;

  skew_shift_buffer #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .shift_en(shift_en), .mode(mode),
    .cfg_delay(cfg_delay), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .flush(flush), .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  // Reference model: remembers what entered at each advance and reads outputs
  // back from that history by lane delay.
  typedef struct {
    logic [LANES*DATA_W-1:0] d;
    logic [LANES-1:0]        v;
  } ent_t;

  ent_t hist[$];
  logic [LANES*DATA_W-1:0] m_od;
  logic [LANES-1:0]        m_ov;
  int m_state;   // 0 idle, 1 active, 2 drain
  int m_cnt;
  bit m_mode;
  int m_cfg;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit m_busy();
    bit b = 0;
    for (int j = 0; j < DEPTH; j++) begin
      int idx = hist.size() - 1 - j;
      if (idx >= 0 && |hist[idx].v) b = 1;
    end
    return b;
  endfunction

  task automatic model_edge();
    ent_t e;
    bit adv, bnow, entered;
    if (reset) begin
      hist.delete();
      m_od = '0; m_ov = '0; m_state = 0; m_cnt = 0; m_mode = 0; m_cfg = 0;
      return;
    end
    bnow = m_busy();
    adv  = (shift_en && m_state != 2) || (m_state == 2);
    e.v  = (m_state == 2) ? '0 : in_valid;
    e.d  = in_data;
`ifdef ZERO_INVALID_EN
    for (int i = 0; i < LANES; i++) if (!e.v[i]) e.d[i*DATA_W +: DATA_W] = '0;
`endif
    entered = adv && (|e.v);
    if (adv) begin
      hist.push_back(e);
      if (hist.size() > DEPTH + 1) void'(hist.pop_front());
      for (int i = 0; i < LANES; i++) begin
        int dl  = m_mode ? imin(i, DEPTH) : m_cfg;
        int idx = hist.size() - 1 - dl;
        if (idx >= 0) begin
          m_od[i*DATA_W +: DATA_W] = hist[idx].d[i*DATA_W +: DATA_W];
          m_ov[i] = hist[idx].v[i];
        end else begin
          m_od[i*DATA_W +: DATA_W] = '0;
          m_ov[i] = 1'b0;
        end
      end
    end
    if (!bnow && m_state == 0) begin
      m_mode = mode;
      m_cfg  = imin(int'(cfg_delay), DEPTH);
    end
    case (m_state)
      0: if (flush) begin m_state = 2; m_cnt = 0; end
         else if (entered) m_state = 1;
      1: if (flush) begin m_state = 2; m_cnt = 0; end
         else if (!bnow && !entered) m_state = 0;
      default: if (m_cnt == DEPTH) begin m_state = 0; m_cnt = 0; end
               else m_cnt++;
    endcase
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_data",   64'(out_data),   64'(m_od));
    chk("out_valid",  64'(out_valid),  64'(m_ov));
    chk("busy",       64'(busy),       64'(m_busy()));
    chk("in_ready",   64'(in_ready),   64'(m_state != 2));
    chk("flush_done", 64'(flush_done), 64'(m_state == 2 && m_cnt == DEPTH));
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic quiet();
    shift_en = 0; in_valid = '0; flush = 0; reset = 0;
  endtask

  int ir_low, fd_cnt;

  initial begin
    reset = 1; shift_en = 0; mode = 0; cfg_delay = '0; in_valid = '0;
    in_data = '0; flush = 0;

    // Reset held two cycles
    cyc(); cyc();
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    quiet();

    // Uniform delay 2
    mode = 0; cfg_delay = 3'd2; cyc();
    in_valid = 4'hF; in_data = 64'h4444_3333_2222_1111; shift_en = 1; cyc();
    in_valid = '0; in_data = 64'h0bad_0bad_0bad_0bad; cyc(); cyc();
    chk("uni_data", 64'(out_data), 64'h4444_3333_2222_1111);
    chk("uni_valid", 64'(out_valid), 64'hF);
    for (int i = 0; i < 6; i++) cyc();

    // Skew mode, single beat
    quiet(); mode = 1; cyc();
    shift_en = 1; in_valid = 4'hF; in_data = 64'hA003_A002_A001_A000; cyc();
    chk("skew_v0", 64'(out_valid), 64'h1);
    in_valid = '0; in_data = '0; cyc(); cyc(); cyc();
    chk("skew_v3", 64'(out_valid), 64'h8);
    chk("skew_d3", 64'(out_data[3*DATA_W +: DATA_W]), 64'hA003);
    for (int i = 0; i < 6; i++) cyc();

    // Stall: uniform delay 2 with shift_en low for two cycles
    quiet(); mode = 0; cfg_delay = 3'd2; cyc();
    shift_en = 1; in_valid = 4'hF; in_data = 64'h8888_7777_6666_5555; cyc();
    in_valid = '0; shift_en = 0; cyc(); cyc();
    chk("stall_hold", 64'(out_valid), 64'h0);
    shift_en = 1; cyc(); cyc();
    chk("stall_out", 64'(out_data), 64'h8888_7777_6666_5555);
    for (int i = 0; i < 6; i++) cyc();

    // Config freeze: launched with delay 3, port changed to 1 in flight
    quiet(); cfg_delay = 3'd3; cyc();
    shift_en = 1; in_valid = 4'hF; in_data = 64'hC0C3_C0C2_C0C1_C0C0; cyc();
    in_valid = '0; cfg_delay = 3'd1; cyc(); cyc(); cyc();
    chk("freeze_out", 64'(out_valid), 64'hF);
    for (int i = 0; i < 8; i++) cyc();
    in_valid = 4'h5; in_data = 64'h1234_5678_9abc_def0; cyc();
    in_valid = '0; cyc();
    chk("newcfg_out", 64'(out_valid), 64'h5);
    for (int i = 0; i < 6; i++) cyc();

    // Flush with clamped delay (7 -> 4)
    quiet(); cfg_delay = 3'd7; cyc();
    shift_en = 1; in_valid = 4'hA; in_data = 64'hF00D_BEEF_CAFE_D00D; cyc();
    shift_en = 0; in_valid = '0; flush = 1; cyc();
    flush = 0;
    ir_low = 0; fd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (i == 2) flush = 1;          // ignored during drain
      if (i == 3) flush = 0;
      if (!in_ready) ir_low++;
      if (flush_done) fd_cnt++;
      cyc();
    end
    chk("flush_ready_low", 64'(ir_low), 64'd5);
    chk("flush_done_cnt", 64'(fd_cnt), 64'd1);
    chk("flush_empty", 64'(busy), 64'd0);

    // Reset in the middle of a drain
    quiet(); shift_en = 1; in_valid = 4'hF; in_data = 64'h1; cyc();
    flush = 1; cyc(); flush = 0; cyc();
    reset = 1; cyc(); reset = 0;
    chk("rst_drain_ready", 64'(in_ready), 64'd1);
    chk("rst_drain_busy", 64'(busy), 64'd0);
    cyc(); cyc();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      reset    = ($urandom_range(0, 199) == 0);
      flush    = ($urandom_range(0, 24) == 0);
      shift_en = ($urandom_range(0, 3) != 0);
      in_valid = LANES'($urandom);
      in_data  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) mode = 1'($urandom);
      cfg_delay = CW'($urandom_range(0, 7));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end
endmodule
